// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Remainder is presented on hi_out, quotient on lo_out.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  output logic             div_stall,
  output logic             ready,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] rem, rem_nx;
  logic [WIDTH-1:0] quo, quo_nx;
  logic [WIDTH-1:0] dvsr, dvsr_nx;
  logic             neg_q, neg_q_nx;
  logic             neg_r, neg_r_nx;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             show;

  assign a_neg = signed_div & a[WIDTH-1];
  assign b_neg = signed_div & b[WIDTH-1];
  assign abs_a = a_neg ? -a : a;
  assign abs_b = b_neg ? -b : b;

  // quo doubles as the dividend shift register; its MSB feeds rem
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvsr};

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rem_nx   = rem;
    quo_nx   = quo;
    dvsr_nx  = dvsr;
    neg_q_nx = neg_q;
    neg_r_nx = neg_r;
    unique case (state)
      IDLE: begin
        if (start && !annul) begin
          cnt_nx = '0;
          if (b == '0) begin
            rem_nx   = a;
            quo_nx   = '1;
            neg_q_nx = 1'b0;
            neg_r_nx = 1'b0;
            state_nx = DONE;
          end else begin
            rem_nx   = '0;
            quo_nx   = abs_a;
            dvsr_nx  = abs_b;
            neg_q_nx = a_neg ^ b_neg;
            neg_r_nx = a_neg;
            state_nx = BUSY;
          end
        end
      end
      BUSY: begin
        if (trial[WIDTH]) begin
          rem_nx = shifted[WIDTH-1:0];
          quo_nx = {quo[WIDTH-2:0], 1'b0};
        end else begin
          rem_nx = trial[WIDTH-1:0];
          quo_nx = {quo[WIDTH-2:0], 1'b1};
        end
        cnt_nx = cnt + 1'b1;
        if (annul) begin
          state_nx = IDLE;
        end else if (cnt == LAST) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      rem   <= rem_nx;
      quo   <= quo_nx;
      dvsr  <= dvsr_nx;
      neg_q <= neg_q_nx;
      neg_r <= neg_r_nx;
    end
  end

  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem : rem;

  // an annulled DONE cycle shows and keeps the previous result
  assign show = (state == DONE) && !annul;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (show) begin
      hi_q <= r_fix;
      lo_q <= q_fix;
    end
  end

  assign ready     = show;
  assign hi_out    = show ? r_fix : hi_q;
  assign lo_out    = show ? q_fix : lo_q;
  assign div_stall = ((state == IDLE) && start) || (state == BUSY);

endmodule
